spi_master_ctrl: RTL and testbench
==================================

# spi_master_ctrl

SPI master sequencer for the 8-bit LSB-first shift register. It accepts a byte on a valid/ready handshake and drives the register's `load` and `shift` strobes. It generates SCLK and active-low chip select in SPI mode 0 (CPOL=0, CPHA=0), captures MISO into a received byte, and reports completion. It sits between the system-side byte interface and the SPI pins.

## Interface
- `CLK_DIV`, default 2: SCLK half-period in `clk` cycles; legal range 1..255.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `tx_data`  in  8  byte to transmit, sampled on handshake.
- `tx_valid`  in  1  request to transmit `tx_data`.
- `tx_ready`  out  1  block can accept a byte; reset 1.
- `rx_data`  out  8  last received byte, held until next completion; reset 0.
- `rx_valid`  out  1  one-cycle completion pulse; reset 0.
- `busy`  out  1  high from acceptance until return to IDLE; reset 0.
- `sr_parallel`  out  8  drives the shift register's parallel input; reset 0.
- `sr_load`  out  1  shift register load strobe; reset 0.
- `sr_shift`  out  1  shift register shift strobe; reset 0.
- `sr_serial`  in  1  shift register serial output (current TX bit).
- `sclk`  out  1  SPI clock; idles 0; reset 0.
- `cs_n`  out  1  chip select, active low; reset 1.
- `mosi`  out  1  `sr_serial` while `cs_n`=0, else 0; reset 0.
- `miso`  in  1  SPI data from slave.

## Operation
- States: IDLE, LOAD, LEAD, XFER_HI, XFER_LO, TRAIL, DONE.
- IDLE:
  - `tx_ready`=1.
  - `tx_valid`&&`tx_ready` at a clock edge latches `tx_data` and moves to LOAD.
- LOAD: 1 cycle.
  - `sr_load`=1, with `sr_parallel` = latched byte.
  - `cs_n` goes low in this cycle.
- LEAD: `CLK_DIV` cycles, `sclk`=0, `cs_n`=0. Bit 0 is already on `mosi`.
- XFER_HI: `CLK_DIV` cycles, `sclk`=1.
  - In its last cycle, `sr_shift`=1 and `miso` is captured into `rx_data` bit [bit index], LSB first.
- XFER_LO: `CLK_DIV` cycles, `sclk`=0.
  - 3-bit counter increments on leaving XFER_LO.
  - After bit 7, go to TRAIL; otherwise go to XFER_HI.
- TRAIL: `CLK_DIV` cycles, `sclk`=0, `cs_n`=0.
- DONE: 1 cycle.
  - `cs_n`=1, `rx_valid`=1, `rx_data` updated (new byte visible in this cycle), `tx_ready`=0.
  - Next state IDLE.
- `sr_shift` is issued on all 8 bits. Register content after the 8th shift is don't-care.
- `tx_valid` outside IDLE is ignored. `tx_data` changes after acceptance have no effect.
- Reset asserted mid-transfer: all outputs return to reset values immediately (asynchronously), and the state goes to IDLE. No `rx_valid` is issued for the aborted byte.
- `sr_load` and `sr_shift` are never high in the same cycle.

## Timing
- Cycle 0 is the acceptance edge; cycle 1 is LOAD.
- First SCLK rise: cycle `CLK_DIV`+2.
- `rx_valid` (DONE): cycle 18·`CLK_DIV`+2. For `CLK_DIV`=2, that is cycle 38.
- `tx_ready` returns to 1 in cycle 18·`CLK_DIV`+3.
- SCLK period is 2·`CLK_DIV` cycles with 50% duty.
- `cs_n` low-to-first-rise and last-fall-to-`cs_n`-high are each ≥ `CLK_DIV` cycles.
- MOSI changes only on the clock edge where SCLK falls (the edge ending XFER_HI). MISO is sampled on that same edge.
- Non-burst minimum `cs_n` high time between bytes: 2 cycles (DONE + IDLE).

## Configuration
- Macro `SPI_CTRL_BURST_EN`.
- Defined:
  - DONE keeps `cs_n`=0 and drives `tx_ready`=1.
  - A handshake in DONE goes straight to LOAD with `cs_n` held low; LEAD is still applied.
  - With no handshake in DONE, go to IDLE, with `cs_n`=1 from the next cycle.
- Undefined: behaviour exactly as in Operation. `cs_n` rises between every byte.

## Structure
- Package `spi_pkg`:
  - state enum `spi_state_t`.
  - `SPI_BITS`=8.
  - `SPI_CLK_DIV_DEF`=2.
  - `SPI_DIV_W`=8.
- Sub-module `spi_sclk_div`:
  - divider counter.
  - `enable` and `clear` inputs.
  - one-cycle `phase_end` tick every `CLK_DIV` cycles.
  - used for LEAD, XFER_HI, XFER_LO and TRAIL timing.

## Test plan
- Reset: after reset, `cs_n`=1, `sclk`=0, `tx_ready`=1, `rx_valid`=0, `rx_data`=0x00.
- Loopback (`miso`=`mosi`, model register attached), `CLK_DIV`=2, send 0xA5 → MOSI bits 1,0,1,0,0,1,0,1 on successive rises; `rx_data`=0xA5; `rx_valid` in cycle 38.
- `miso` tied 1, send 0x00 → `rx_data`=0xFF; exactly 8 SCLK rises; `sr_shift` pulses 8 times; `sr_load` pulses once.
- `CLK_DIV`=1, send 0x3C → SCLK period 2 cycles; `rx_valid` in cycle 20.
- Reset asserted after 4th SCLK rise → immediate `cs_n`=1, `sclk`=0, no `rx_valid`; the next byte 0x81 transfers correctly.
- Burst (macro defined), `tx_valid` held with 0x12 then 0x34 → `cs_n` low throughout, 16 SCLK rises, two `rx_valid` pulses. Without the macro, `cs_n` goes high for 2 cycles between the bytes.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master sequencer.
package spi_pkg;

    localparam int SPI_BITS        = 8;
    localparam int SPI_CLK_DIV_DEF = 2;
    localparam int SPI_DIV_W       = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LEAD,
        XFER_HI,
        XFER_LO,
        TRAIL,
        DONE
    } spi_state_t;

endpackage

// File: rtl/spi_master_ctrl_if.sv
// System-side byte interface of the SPI master: transmit handshake, received byte, status.
interface spi_master_ctrl_if
    import spi_pkg::*;
();

    logic [SPI_BITS-1:0] tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic [SPI_BITS-1:0] rx_data;
    logic                rx_valid;
    logic                busy;

    modport master (output tx_data, tx_valid, input tx_ready, rx_data, rx_valid, busy);
    modport slave  (input tx_data, tx_valid, output tx_ready, rx_data, rx_valid, busy);

endinterface

// File: rtl/spi_sclk_div.sv
// Phase timer: emits a one-cycle phase_end tick after every CLK_DIV enabled cycles.
module spi_sclk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic phase_end
);

    localparam logic [SPI_DIV_W-1:0] LAST = SPI_DIV_W'(CLK_DIV - 1);

    logic [SPI_DIV_W-1:0] cnt;

    assign phase_end = enable && (cnt == LAST);

    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || !enable || phase_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master sequencer driving an external 8-bit LSB-first shift register.
// Define SPI_CTRL_BURST_EN to keep cs_n low across back-to-back bytes.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV_DEF
) (
    input  logic                clk,
    input  logic                rst,
    spi_master_ctrl_if.slave    bus,
    output logic [SPI_BITS-1:0] sr_parallel,
    output logic                sr_load,
    output logic                sr_shift,
    input  logic                sr_serial,
    output logic                sclk,
    output logic                cs_n,
    output logic                mosi,
    input  logic                miso
);

    localparam int CNT_W = $clog2(SPI_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SPI_BITS - 1);

    spi_state_t          state, next;
    logic [SPI_BITS-1:0] tx_byte;
    logic [SPI_BITS-1:0] rx_shift;
    logic [SPI_BITS-1:0] rx_byte;
    logic [CNT_W-1:0]    bit_cnt;
    logic                phase_end;
    logic                div_en;
    logic                tx_ready;
    logic                rx_valid;
    logic                accept;

    assign div_en = (state == LEAD) || (state == XFER_HI) ||
                    (state == XFER_LO) || (state == TRAIL);

    spi_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk       (clk),
        .rst       (rst),
        .enable    (div_en),
        .clear     (state == LOAD),
        .phase_end (phase_end)
    );

`ifdef SPI_CTRL_BURST_EN
    assign tx_ready = (state == IDLE) || (state == DONE);
`else
    assign tx_ready = (state == IDLE);
`endif
    assign accept = bus.tx_valid && tx_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        next     = state;
        cs_n     = 1'b1;
        sclk     = 1'b0;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        rx_valid = 1'b0;
        case (state)
            IDLE: if (accept) next = LOAD;
            LOAD: begin
                cs_n    = 1'b0;
                sr_load = 1'b1;
                next    = LEAD;
            end
            LEAD: begin
                cs_n = 1'b0;
                if (phase_end) next = XFER_HI;
            end
            XFER_HI: begin
                cs_n = 1'b0;
                sclk = 1'b1;
                if (phase_end) begin
                    sr_shift = 1'b1;
                    next     = XFER_LO;
                end
            end
            XFER_LO: begin
                cs_n = 1'b0;
                if (phase_end) next = (bit_cnt == LAST_BIT) ? TRAIL : XFER_HI;
            end
            TRAIL: begin
                cs_n = 1'b0;
                if (phase_end) next = DONE;
            end
            DONE: begin
                rx_valid = 1'b1;
`ifdef SPI_CTRL_BURST_EN
                cs_n = 1'b0;
                next = accept ? LOAD : IDLE;
`else
                next = IDLE;
`endif
            end
            default: next = IDLE;
        endcase
    end

    // NOTE: datapath registers are reset too, so an aborted byte leaves nothing visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_byte  <= '0;
            rx_shift <= '0;
            rx_byte  <= '0;
            bit_cnt  <= '0;
        end else begin
            if (accept) tx_byte <= bus.tx_data;
            if (state == LOAD) begin
                bit_cnt <= '0;
            end else if (state == XFER_LO && phase_end) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            // MISO is captured on the same edge that drops SCLK and shifts MOSI.
            if (state == XFER_HI && phase_end) rx_shift[bit_cnt] <= miso;
            if (state == TRAIL && phase_end) rx_byte <= rx_shift;
        end
    end

    assign sr_parallel  = tx_byte;
    assign mosi         = !cs_n && sr_serial;
    assign bus.tx_ready = tx_ready;
    assign bus.rx_valid = rx_valid;
    assign bus.rx_data  = rx_byte;
    assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: CLK_DIV=2 and CLK_DIV=1 instances, each with a model shift register.
module tb_spi_master_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

`ifdef SPI_CTRL_BURST_EN
    localparam int RDY_CYC = 38;
    localparam int CS_RISES = 1;
`else
    localparam int RDY_CYC = 39;
    localparam int CS_RISES = 2;
`endif

    spi_master_ctrl_if bus_a();
    spi_master_ctrl_if bus_b();

    logic [7:0] par_a, par_b, reg_a, reg_b;
    logic load_a, load_b, shift_a, shift_b, ser_a, ser_b;
    logic sclk_a, sclk_b, cs_a, cs_b, mosi_a, mosi_b, miso_a, miso_b;
    logic [1:0] mode_a = 2'd0;  // 0: loopback, 1: miso tied 0, 2: miso tied 1

    spi_master_ctrl #(.CLK_DIV(2)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .sr_parallel(par_a), .sr_load(load_a),
        .sr_shift(shift_a), .sr_serial(ser_a), .sclk(sclk_a), .cs_n(cs_a),
        .mosi(mosi_a), .miso(miso_a)
    );

    spi_master_ctrl #(.CLK_DIV(1)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .sr_parallel(par_b), .sr_load(load_b),
        .sr_shift(shift_b), .sr_serial(ser_b), .sclk(sclk_b), .cs_n(cs_b),
        .mosi(mosi_b), .miso(miso_b)
    );

    // Attached 8-bit LSB-first shift registers.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_a <= 8'h00;
            reg_b <= 8'h00;
        end else begin
            if (load_a) reg_a <= par_a;
            else if (shift_a) reg_a <= {1'b0, reg_a[7:1]};
            if (load_b) reg_b <= par_b;
            else if (shift_b) reg_b <= {1'b0, reg_b[7:1]};
        end
    end
    assign ser_a  = reg_a[0];
    assign ser_b  = reg_b[0];
    assign miso_a = (mode_a == 2'd0) ? mosi_a : (mode_a == 2'd2);
    assign miso_b = mosi_b;

    // Monitor A: cycle numbers are counted from the cycle that ends in the acceptance edge.
    int ncyc_a = 0, acc_a = 0, rxcyc_a = 0, rdycyc_a = 0, rises_a = 0, shifts_a = 0;
    int loads_a = 0, rxv_a = 0, csrise_a = 0, csrun_a = 0, csgap_a = 0, lastrise_a = 0, per_a = 0;
    logic [7:0]  mcap_a = 8'h00;
    logic [15:0] hist_a = 16'h0000;
    logic overlap_a = 1'b0, sclk_pa = 1'b0, cs_pa = 1'b1, rdy_pa = 1'b1;

    always @(negedge clk) begin
        ncyc_a  <= ncyc_a + 1;
        sclk_pa <= sclk_a;
        cs_pa   <= cs_a;
        rdy_pa  <= bus_a.tx_ready;
        if (bus_a.tx_valid && bus_a.tx_ready) acc_a <= ncyc_a;
        if (sclk_a && !sclk_pa) begin
            rises_a    <= rises_a + 1;
            mcap_a     <= {mosi_a, mcap_a[7:1]};
            per_a      <= ncyc_a - lastrise_a;
            lastrise_a <= ncyc_a;
        end
        if (shift_a) shifts_a <= shifts_a + 1;
        if (load_a) loads_a <= loads_a + 1;
        if (load_a && shift_a) overlap_a <= 1'b1;
        if (bus_a.rx_valid) begin
            rxv_a   <= rxv_a + 1;
            rxcyc_a <= ncyc_a - acc_a;
            hist_a  <= {hist_a[7:0], bus_a.rx_data};
        end
        if (bus_a.tx_ready && !rdy_pa) rdycyc_a <= ncyc_a - acc_a;
        if (cs_a) begin
            csrun_a <= csrun_a + 1;
            if (!cs_pa) csrise_a <= csrise_a + 1;
        end else begin
            csrun_a <= 0;
            if (cs_pa) csgap_a <= csrun_a;
        end
    end

    int ncyc_b = 0, acc_b = 0, rxcyc_b = 0, rxv_b = 0, rises_b = 0, lastrise_b = 0, per_b = 0;
    logic sclk_pb = 1'b0;

    always @(negedge clk) begin
        ncyc_b  <= ncyc_b + 1;
        sclk_pb <= sclk_b;
        if (bus_b.tx_valid && bus_b.tx_ready) acc_b <= ncyc_b;
        if (sclk_b && !sclk_pb) begin
            rises_b    <= rises_b + 1;
            per_b      <= ncyc_b - lastrise_b;
            lastrise_b <= ncyc_b;
        end
        if (bus_b.rx_valid) begin
            rxv_b   <= rxv_b + 1;
            rxcyc_b <= ncyc_b - acc_b;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready_a();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_a.tx_ready && n < 200);
        check("ready_wait_a", 32'(bus_a.tx_ready), 32'd1);
    endtask

    task automatic send_a(input logic [7:0] b, input int hold);
        @(posedge clk);
        #1 bus_a.tx_data = b;
        bus_a.tx_valid = 1'b1;
        wait_ready_a();
        @(posedge clk);
        // Scrambled data and a lingering valid after acceptance must be ignored.
        #1 bus_a.tx_data = ~b;
        repeat (hold) @(posedge clk);
        #1 bus_a.tx_valid = 1'b0;
    endtask

    task automatic wait_rx_a(input int target);
        int n = 0;
        while (rxv_a < target && n < 300) begin
            @(posedge clk);
            n++;
        end
        check("rx_wait_a", 32'(rxv_a >= target), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [1:0] mode;
        logic [7:0] rx;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b_r, b_s, b_l, b_v, b_c, n;

        vecs[0] = '{tx: 8'hA5, mode: 2'd0, rx: 8'hA5};
        vecs[1] = '{tx: 8'h00, mode: 2'd2, rx: 8'hFF};
        vecs[2] = '{tx: 8'h3C, mode: 2'd0, rx: 8'h3C};
        vecs[3] = '{tx: 8'hFF, mode: 2'd1, rx: 8'h00};
        vecs[4] = '{tx: 8'h6E, mode: 2'd2, rx: 8'hFF};

        bus_a.tx_valid = 1'b0;
        bus_a.tx_data  = 8'h00;
        bus_b.tx_valid = 1'b0;
        bus_b.tx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_cs_n", 32'(cs_a), 32'd1);
        check("rst_sclk", 32'(sclk_a), 32'd0);
        check("rst_tx_ready", 32'(bus_a.tx_ready), 32'd1);
        check("rst_rx_valid", 32'(bus_a.rx_valid), 32'd0);
        check("rst_rx_data", 32'(bus_a.rx_data), 32'h00);
        check("rst_busy", 32'(bus_a.busy), 32'd0);
        check("rst_mosi", 32'(mosi_a), 32'd0);

        for (int i = 0; i < 5; i++) begin
            mode_a = vecs[i].mode;
            b_r = rises_a;
            b_s = shifts_a;
            b_l = loads_a;
            b_v = rxv_a;
            send_a(vecs[i].tx, 3);
            wait_rx_a(b_v + 1);
            check("vec_rx_data", 32'(bus_a.rx_data), 32'(vecs[i].rx));
            check("vec_mosi_bits", 32'(mcap_a), 32'(vecs[i].tx));
            check("vec_sclk_rises", 32'(rises_a - b_r), 32'd8);
            check("vec_shift_pulses", 32'(shifts_a - b_s), 32'd8);
            check("vec_load_pulses", 32'(loads_a - b_l), 32'd1);
            check("vec_rx_pulses", 32'(rxv_a - b_v), 32'd1);
            check("vec_rx_cycle", 32'(rxcyc_a), 32'd38);
            check("vec_ready_cycle", 32'(rdycyc_a), 32'(RDY_CYC));
            check("vec_sclk_period", 32'(per_a), 32'd4);
        end
        check("load_shift_overlap", 32'(overlap_a), 32'd0);

        // Abort after the fourth SCLK rise.
        mode_a = 2'd0;
        b_v = rxv_a;
        b_r = rises_a;
        send_a(8'h5A, 3);
        n = 0;
        while (rises_a - b_r < 4 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("abort_rise_wait", 32'(rises_a - b_r), 32'd4);
        #1 rst = 1'b0;
        #1;
        check("abort_cs_n", 32'(cs_a), 32'd1);
        check("abort_sclk", 32'(sclk_a), 32'd0);
        check("abort_busy", 32'(bus_a.busy), 32'd0);
        check("abort_rx_valid", 32'(bus_a.rx_valid), 32'd0);
        check("abort_sr_shift", 32'(shift_a), 32'd0);
        check("abort_mosi", 32'(mosi_a), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        check("abort_no_rx_valid", 32'(rxv_a - b_v), 32'd0);
        send_a(8'h81, 3);
        wait_rx_a(b_v + 1);
        check("after_abort_rx", 32'(bus_a.rx_data), 32'h81);
        check("after_abort_mosi", 32'(mcap_a), 32'h81);
        check("after_abort_cycle", 32'(rxcyc_a), 32'd38);

        // Back-to-back bytes with tx_valid held.
        b_r = rises_a;
        b_v = rxv_a;
        b_c = csrise_a;
        @(posedge clk);
        #1 bus_a.tx_data = 8'h12;
        bus_a.tx_valid = 1'b1;
        wait_ready_a();
        @(posedge clk);
        #1 bus_a.tx_data = 8'h34;
        wait_ready_a();
        @(posedge clk);
        #1 bus_a.tx_valid = 1'b0;
        wait_rx_a(b_v + 2);
        check("b2b_rx_pair", 32'(hist_a), 32'h1234);
        check("b2b_rx_pulses", 32'(rxv_a - b_v), 32'd2);
        check("b2b_sclk_rises", 32'(rises_a - b_r), 32'd16);
        check("b2b_cs_rises", 32'(csrise_a - b_c), 32'(CS_RISES));
`ifndef SPI_CTRL_BURST_EN
        check("b2b_cs_gap", 32'(csgap_a), 32'd2);
`endif

        // CLK_DIV=1 instance.
        @(posedge clk);
        #1 bus_b.tx_data = 8'h3C;
        bus_b.tx_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_b.tx_ready && n < 200);
        @(posedge clk);
        #1 bus_b.tx_valid = 1'b0;
        n = 0;
        while (rxv_b < 1 && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("div1_rx_pulses", 32'(rxv_b), 32'd1);
        check("div1_rx_data", 32'(bus_b.rx_data), 32'h3C);
        check("div1_rx_cycle", 32'(rxcyc_b), 32'd20);
        check("div1_sclk_period", 32'(per_b), 32'd2);
        check("div1_sclk_rises", 32'(rises_b), 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
